calc_op_sequencer: RTL and testbench
====================================

// Module: calc_op_sequencer
// PURPOSE
//  Sequences one calculator operation at a time through the 16-bit datapath.
//  - Accepts operands and an opcode over a valid/ready handshake.
//  - Drives the 4:1 result-mux select and start pulses for the multi-cycle MUL/DIV units.
//  - Captures the selected mux output, then presents the result with backpressure.
// PARAMETERS
//  WIDTH    16  operand/result width
//  TIMEOUT  64  max wait cycles for mul_done/div_done before error abort
//  TCNT_W   7   timeout counter width; must hold TIMEOUT
// PORTS
//  clk         in   1      single clock, all state on rising edge
//  rst_n       in   1      synchronous reset, active-low
//  in_valid    in   1      request valid
//  in_ready    out  1      request accepted when in_valid & in_ready
//  in_a        in   WIDTH  operand A
//  in_b        in   WIDTH  operand B
//  in_op       in   2      00 ADD, 01 SUB, 10 MUL, 11 DIV
//  dp_a        out  WIDTH  latched operand A to datapath
//  dp_b        out  WIDTH  latched operand B to datapath
//  dp_sel      out  2      result-mux select (= latched op)
//  mul_start   out  1      1-cycle start pulse to multiplier
//  div_start   out  1      1-cycle start pulse to divider
//  mul_done    in   1      multiplier result valid on dp_y
//  div_done    in   1      divider result valid on dp_y
//  dp_y        in   WIDTH  result-mux output
//  out_valid   out  1      result valid
//  out_ready   in   1      consumer ready
//  out_result  out  WIDTH  captured result
//  out_err     out  1      error flag, qualified by out_valid
// BEHAVIOUR
//  Reset (rst_n low at a clk edge):
//   - state=IDLE.
//   - dp_a, dp_b, dp_sel, out_result and timeout counter all 0.
//   - out_err, out_valid, mul_start and div_start are 0.
//   - in_ready=0 while rst_n is low. Reset overrides every state, including mid-WAIT.
//  States: IDLE, EXEC, WAIT, DONE. in_ready=1 only in IDLE; requests are never accepted in other states.
//  IDLE, on accept:
//   - latch a/b/op into dp_a/dp_b/dp_sel. dp_sel and operands then hold until the next accept.
//   - op 00/01 -> EXEC.
//   - op 10 -> WAIT, and mul_start=1 on the first WAIT cycle.
//   - op 11 with in_b!=0 -> WAIT, and div_start=1 on the first WAIT cycle.
//   - op 11 with in_b==0 -> DONE directly, out_result=16'hFFFF, out_err=1, no div_start.
//  EXEC (1 cycle):
//   - out_result<=dp_y, out_err<=0, -> DONE.
//   - ADD/SUB latency: out_valid is high 2 cycles after the accept edge.
//  WAIT:
//   - Start pulse is exactly one cycle. The done input is ignored during the start cycle.
//   - Counter clears on entry and increments each subsequent WAIT cycle.
//   - Matching done (mul_done for op 10, div_done for op 11) -> out_result<=dp_y, out_err<=0, -> DONE.
//   - Non-matching done is ignored.
//   - Counter reaching TIMEOUT with no matching done -> out_result<=0, out_err<=1, -> DONE.
//   - If matching done and timeout occur in the same cycle, done wins.
//  DONE:
//   - out_valid=1. out_result/out_err are stable while out_valid & !out_ready.
//   - out_valid & out_ready -> IDLE, out_valid=0 next cycle.
//   - No same-cycle re-accept: minimum 1 IDLE cycle between results.
//  Arithmetic: none in this block; results pass through unmodified, WIDTH bits, no truncation.
// TESTING
//  1. ADD a=0x0003 b=0x0004, op 00 -> dp_sel=00; out_valid 2 cycles after accept; result 0x0007, err=0.
//  2. MUL a=0x0012 b=0x0003, model mul_done 5 cycles after start -> single mul_start pulse; result 0x0036, err=0.
//  3. DIV a=0x0010 b=0x0000 -> no div_start; next cycle out_valid, result 0xFFFF, err=1.
//  4. DIV with div_done never asserted -> out_valid after TIMEOUT WAIT cycles; result 0x0000, err=1.
//     mul_done pulses during WAIT are ignored.
//  5. out_ready held low 10 cycles in DONE -> out_valid, result and err constant; in_ready=0.
//     New in_valid is not accepted until after the handshake.
//  6. rst_n low for 1 cycle mid-WAIT -> next cycle IDLE; all outputs 0; in_ready=1 after release.
//     A late mul_done is ignored.

Source files
------------

// File: rtl/calc_op_sequencer_if.sv
// Handshake and datapath-control bundle between the calculator sequencer and its environment.
interface calc_op_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [1:0]       in_op;
    logic [WIDTH-1:0] dp_a;
    logic [WIDTH-1:0] dp_b;
    logic [1:0]       dp_sel;
    logic             mul_start;
    logic             div_start;
    logic             mul_done;
    logic             div_done;
    logic [WIDTH-1:0] dp_y;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_err;

    modport master (
        output in_valid, in_a, in_b, in_op, mul_done, div_done, dp_y, out_ready,
        input  in_ready, dp_a, dp_b, dp_sel, mul_start, div_start,
               out_valid, out_result, out_err
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, mul_done, div_done, dp_y, out_ready,
        output in_ready, dp_a, dp_b, dp_sel, mul_start, div_start,
               out_valid, out_result, out_err
    );
endinterface

// File: rtl/calc_op_sequencer.sv
// Runs one ADD/SUB/MUL/DIV request at a time: latches operands, drives the result-mux
// select and MUL/DIV start pulses, captures dp_y and holds it until the consumer takes it.
module calc_op_sequencer #(
    parameter int WIDTH   = 16,
    parameter int TIMEOUT = 64,
    parameter int TCNT_W  = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    calc_op_sequencer_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state_r;
    logic [TCNT_W-1:0] tcnt_r;
    logic [WIDTH-1:0]  dp_a_r;
    logic [WIDTH-1:0]  dp_b_r;
    logic [1:0]        dp_sel_r;
    logic              in_ready_r;
    logic              mul_start_r;
    logic              div_start_r;
    logic              out_valid_r;
    logic [WIDTH-1:0]  out_result_r;
    logic              out_err_r;
    logic              accept_s;
    logic              match_done_s;

    assign bus.in_ready   = in_ready_r;
    assign bus.dp_a       = dp_a_r;
    assign bus.dp_b       = dp_b_r;
    assign bus.dp_sel     = dp_sel_r;
    assign bus.mul_start  = mul_start_r;
    assign bus.div_start  = div_start_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_result = out_result_r;
    assign bus.out_err    = out_err_r;

    // Request acceptance and selection of the done line belonging to the latched op
    always_comb begin
        accept_s     = (state_r == IDLE) && bus.in_valid && in_ready_r;
        match_done_s = 1'b0;
        case (dp_sel_r)
            2'b10:   match_done_s = bus.mul_done;
            2'b11:   match_done_s = bus.div_done;
            default: match_done_s = 1'b0;
        endcase
    end

    // Sequencer FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            tcnt_r       <= {TCNT_W{1'b0}};
            dp_a_r       <= {WIDTH{1'b0}};
            dp_b_r       <= {WIDTH{1'b0}};
            dp_sel_r     <= 2'b00;
            in_ready_r   <= 1'b0;
            mul_start_r  <= 1'b0;
            div_start_r  <= 1'b0;
            out_valid_r  <= 1'b0;
            out_result_r <= {WIDTH{1'b0}};
            out_err_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        dp_a_r     <= bus.in_a;
                        dp_b_r     <= bus.in_b;
                        dp_sel_r   <= bus.in_op;
                        in_ready_r <= 1'b0;
                        case (bus.in_op)
                            2'b10: begin
                                state_r     <= WAIT;
                                mul_start_r <= 1'b1;
                                tcnt_r      <= {TCNT_W{1'b0}};
                            end
                            2'b11: begin
                                if (bus.in_b != {WIDTH{1'b0}}) begin
                                    state_r     <= WAIT;
                                    div_start_r <= 1'b1;
                                    tcnt_r      <= {TCNT_W{1'b0}};
                                end else begin
                                    // Divide by zero never reaches the divider
                                    state_r      <= DONE;
                                    out_result_r <= {WIDTH{1'b1}};
                                    out_err_r    <= 1'b1;
                                    out_valid_r  <= 1'b1;
                                end
                            end
                            default: state_r <= EXEC;
                        endcase
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                EXEC: begin
                    out_result_r <= bus.dp_y;
                    out_err_r    <= 1'b0;
                    out_valid_r  <= 1'b1;
                    state_r      <= DONE;
                end
                WAIT: begin
                    if (mul_start_r || div_start_r) begin
                        mul_start_r <= 1'b0;
                        div_start_r <= 1'b0;
                        tcnt_r      <= tcnt_r + TCNT_W'(1);
                    end else if (match_done_s) begin
                        out_result_r <= bus.dp_y;
                        out_err_r    <= 1'b0;
                        out_valid_r  <= 1'b1;
                        state_r      <= DONE;
                    end else if (tcnt_r == TCNT_W'(TIMEOUT - 1)) begin
                        out_result_r <= {WIDTH{1'b0}};
                        out_err_r    <= 1'b1;
                        out_valid_r  <= 1'b1;
                        tcnt_r       <= tcnt_r + TCNT_W'(1);
                        state_r      <= DONE;
                    end else begin
                        tcnt_r <= tcnt_r + TCNT_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state_r     <= IDLE;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    in_ready_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_calc_op_sequencer.sv
// Directed bench for calc_op_sequencer: vector table plus backpressure and mid-WAIT reset sequences.
module tb_calc_op_sequencer;
    localparam int WIDTH   = 16;
    localparam int TIMEOUT = 64;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    calc_op_sequencer_if #(.WIDTH(WIDTH)) ifc ();

    calc_op_sequencer #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT), .TCNT_W(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Datapath stand-in: MUL/DIV results are only meaningful while their done line is high
    logic [WIDTH-1:0] dp_y_s;
    always_comb begin
        case (ifc.dp_sel)
            2'b00:   dp_y_s = ifc.dp_a + ifc.dp_b;
            2'b01:   dp_y_s = ifc.dp_a - ifc.dp_b;
            2'b10:   dp_y_s = ifc.mul_done ? ifc.dp_a * ifc.dp_b : 16'hDEAD;
            default: dp_y_s = (ifc.div_done && ifc.dp_b != 16'h0000) ? ifc.dp_a / ifc.dp_b : 16'hDEAD;
        endcase
    end
    assign ifc.dp_y = dp_y_s;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [1:0]  op;
        int          done_at;
        logic        noise;
        logic [15:0] res;
        logic        err;
        int          lat;
        int          ms;
        int          ds;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (ifc.in_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'd0, ifc.in_ready}, 32'd1);
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
        ifc.in_a     = a;
        ifc.in_b     = b;
        ifc.in_op    = op;
        ifc.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifc.in_valid = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        int ms;
        int ds;
        bit got;
        wait_ready($sformatf("v%0d_in_ready", idx));
        issue(v.a, v.b, v.op);
        n   = 1;
        ms  = 0;
        ds  = 0;
        got = 1'b0;
        while (n < 200 && !got) begin
            ms += int'(ifc.mul_start);
            ds += int'(ifc.div_start);
            if (ifc.out_valid === 1'b1) begin
                got = 1'b1;
            end else begin
                ifc.mul_done = (v.op == 2'b10 && v.done_at > 0 && n == v.done_at + 1) ||
                               (v.noise && (n == 3 || n == 10));
                ifc.div_done = (v.op == 2'b11 && v.done_at > 0 && n == v.done_at + 1);
                @(negedge clk);
                ifc.mul_done = 1'b0;
                ifc.div_done = 1'b0;
                n++;
            end
        end
        chk($sformatf("v%0d_out_valid", idx), {31'd0, got}, 32'd1);
        chk($sformatf("v%0d_result", idx), {16'd0, ifc.out_result}, {16'd0, v.res});
        chk($sformatf("v%0d_err", idx), {31'd0, ifc.out_err}, {31'd0, v.err});
        chk($sformatf("v%0d_latency", idx), n, v.lat);
        chk($sformatf("v%0d_mul_starts", idx), ms, v.ms);
        chk($sformatf("v%0d_div_starts", idx), ds, v.ds);
        chk($sformatf("v%0d_dp_sel", idx), {30'd0, ifc.dp_sel}, {30'd0, v.op});
        chk($sformatf("v%0d_dp_a", idx), {16'd0, ifc.dp_a}, {16'd0, v.a});
        chk($sformatf("v%0d_dp_b", idx), {16'd0, ifc.dp_b}, {16'd0, v.b});
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("v%0d_valid_drop", idx), {31'd0, ifc.out_valid}, 32'd0);
        chk($sformatf("v%0d_ready_back", idx), {31'd0, ifc.in_ready}, 32'd1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_out_valid"}, {31'd0, ifc.out_valid}, 32'd0);
        chk({tag, "_mul_start"}, {31'd0, ifc.mul_start}, 32'd0);
        chk({tag, "_div_start"}, {31'd0, ifc.div_start}, 32'd0);
        chk({tag, "_dp_a"}, {16'd0, ifc.dp_a}, 32'd0);
        chk({tag, "_dp_b"}, {16'd0, ifc.dp_b}, 32'd0);
        chk({tag, "_dp_sel"}, {30'd0, ifc.dp_sel}, 32'd0);
        chk({tag, "_out_result"}, {16'd0, ifc.out_result}, 32'd0);
        chk({tag, "_out_err"}, {31'd0, ifc.out_err}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        int n;
        checks   = 0;
        failures = 0;

        //          a         b         op     done  noise res       err   lat  ms  ds
        vecs[0] = '{16'h0003, 16'h0004, 2'b00, 0,    1'b0, 16'h0007, 1'b0, 2,   0,  0};
        vecs[1] = '{16'h0010, 16'h0003, 2'b01, 0,    1'b0, 16'h000D, 1'b0, 2,   0,  0};
        vecs[2] = '{16'h0000, 16'h0001, 2'b01, 0,    1'b0, 16'hFFFF, 1'b0, 2,   0,  0};
        vecs[3] = '{16'h0012, 16'h0003, 2'b10, 5,    1'b0, 16'h0036, 1'b0, 7,   1,  0};
        vecs[4] = '{16'h0010, 16'h0000, 2'b11, 0,    1'b0, 16'hFFFF, 1'b1, 1,   0,  0};
        vecs[5] = '{16'h0064, 16'h0007, 2'b11, 3,    1'b1, 16'h000E, 1'b0, 5,   0,  1};
        vecs[6] = '{16'h1234, 16'h0002, 2'b11, 0,    1'b1, 16'h0000, 1'b1, 65,  0,  1};
        vecs[7] = '{16'hFFFF, 16'hFFFF, 2'b10, 2,    1'b0, 16'h0001, 1'b0, 4,   1,  0};
        vecs[8] = '{16'h0002, 16'h0003, 2'b10, 63,   1'b0, 16'h0006, 1'b0, 65,  1,  0};
        vecs[9] = '{16'hFFFF, 16'h0001, 2'b00, 0,    1'b0, 16'h0000, 1'b0, 2,   0,  0};

        rst_n         = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.in_a      = 16'h0000;
        ifc.in_b      = 16'h0000;
        ifc.in_op     = 2'b00;
        ifc.mul_done  = 1'b0;
        ifc.div_done  = 1'b0;
        ifc.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'd0, ifc.in_ready}, 32'd0);
        chk_reset_state("rst");
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            run_vec(vecs[i], i);
        end

        // Backpressure: result must hold and no new request may be taken
        ifc.out_ready = 1'b0;
        wait_ready("bp_in_ready");
        issue(16'h0005, 16'h0006, 2'b00);
        n = 0;
        while (ifc.out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        ifc.in_a     = 16'h0100;
        ifc.in_b     = 16'h0001;
        ifc.in_op    = 2'b00;
        ifc.in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("bp%0d_valid", i), {31'd0, ifc.out_valid}, 32'd1);
            chk($sformatf("bp%0d_result", i), {16'd0, ifc.out_result}, 32'h000B);
            chk($sformatf("bp%0d_err", i), {31'd0, ifc.out_err}, 32'd0);
            chk($sformatf("bp%0d_in_ready", i), {31'd0, ifc.in_ready}, 32'd0);
            chk($sformatf("bp%0d_dp_a", i), {16'd0, ifc.dp_a}, 32'h0005);
            @(negedge clk);
        end
        ifc.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_valid", {31'd0, ifc.out_valid}, 32'd0);
        chk("bp_release_in_ready", {31'd0, ifc.in_ready}, 32'd1);
        chk("bp_release_dp_a", {16'd0, ifc.dp_a}, 32'h0005);
        @(posedge clk);
        @(negedge clk);
        ifc.in_valid = 1'b0;
        chk("bp_next_dp_a", {16'd0, ifc.dp_a}, 32'h0100);
        n = 1;
        while (ifc.out_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_next_latency", n, 2);
        chk("bp_next_result", {16'd0, ifc.out_result}, 32'h0101);
        @(posedge clk);
        @(negedge clk);

        // Reset in the middle of a MUL wait, then a late mul_done
        wait_ready("rw_in_ready");
        issue(16'h0007, 16'h0009, 2'b10);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rw_in_ready_low", {31'd0, ifc.in_ready}, 32'd0);
        chk_reset_state("rw");
        ifc.mul_done = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ifc.mul_done = 1'b0;
        chk("rw_in_ready_high", {31'd0, ifc.in_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rw_idle%0d_valid", i), {31'd0, ifc.out_valid}, 32'd0);
            chk($sformatf("rw_idle%0d_result", i), {16'd0, ifc.out_result}, 32'd0);
            @(negedge clk);
        end
        run_vec(vecs[0], 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
